qeciphy_rx_slide_aligner: RTL



---
 rtl/qeciphy_rx_slide_aligner.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/qeciphy_rx_slide_aligner.sv
// RX word aligner: pulses the GTX rxslide until the K28.5 comma sits in
// byte 0, then holds lock while watching for comma drift and code errors.
module qeciphy_rx_slide_aligner #(
    parameter logic [7:0] COMMA         = 8'hBC,
    parameter int         SLIDE_WAIT    = 32,
    parameter int         SEARCH_WINDOW = 256,
    parameter int         MAX_SLIDES    = 40,
    parameter int         LOCK_COUNT    = 8,
    parameter int         ERR_LIMIT     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_resetdone,
    input  logic [31:0] rx_data,
    input  logic [3:0]  rx_charisk,
    input  logic [3:0]  rx_disperr,
    input  logic [3:0]  rx_notintable,
    output logic        rx_slide,
    output logic        aligned,
    output logic        align_fail,
    output logic [5:0]  slide_count
);
    localparam int WW = $clog2(SEARCH_WINDOW) + 1;
    localparam int TW = $clog2(SLIDE_WAIT) + 1;
    localparam int OW = $clog2(LOCK_COUNT) + 1;
    localparam int EW = $clog2(ERR_LIMIT) + 1;
    localparam logic [WW-1:0] WIN_LAST   = WW'(SEARCH_WINDOW - 1);
    localparam logic [TW-1:0] WAIT_LAST  = TW'(SLIDE_WAIT - 1);
    localparam logic [OW-1:0] OK_LAST    = OW'(LOCK_COUNT - 1);
    localparam logic [EW-1:0] ERR_LAST   = EW'(ERR_LIMIT - 1);
    localparam logic [5:0]    SLIDE_LAST = 6'(MAX_SLIDES - 1);

    typedef enum logic [2:0] {
        IDLE, SEARCH, SLIDE, WAIT, VERIFY, LOCKED
    } state_t;

    state_t        state;
    logic [31:0]   data_q;
    logic [3:0]    k_q;
    logic [3:0]    err_q;
    logic          done_q;
    logic [WW-1:0] win_cnt;
    logic [TW-1:0] wait_cnt;
    logic [OW-1:0] ok_cnt;
    logic [EW-1:0] err_cnt;
    logic          comma0;
    logic          comma_other;
    logic          code_err;
    logic          good;
    logic          bad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            k_q    <= '0;
            err_q  <= '0;
            done_q <= 1'b0;
        end else begin
            data_q <= rx_data;
            k_q    <= rx_charisk;
            err_q  <= rx_disperr | rx_notintable;
            done_q <= rx_resetdone;
        end
    end

    always_comb begin
        comma0      = k_q[0] && (data_q[7:0] == COMMA);
        comma_other = 1'b0;
        for (int i = 1; i < 4; i++) begin
            if (k_q[i] && (data_q[8*i +: 8] == COMMA)) comma_other = 1'b1;
        end
        code_err = |err_q;
        // a comma carrying a code error is an error, never a good comma
        good     = comma0 && !code_err;
        bad      = comma_other || code_err;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            win_cnt     <= '0;
            wait_cnt    <= '0;
            ok_cnt      <= '0;
            err_cnt     <= '0;
            rx_slide    <= 1'b0;
            aligned     <= 1'b0;
            align_fail  <= 1'b0;
            slide_count <= '0;
        end else begin
            rx_slide   <= 1'b0;
            align_fail <= 1'b0;
            if (state != IDLE && !done_q) begin
                state       <= IDLE;
                aligned     <= 1'b0;
                win_cnt     <= '0;
                wait_cnt    <= '0;
                ok_cnt      <= '0;
                err_cnt     <= '0;
                slide_count <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        win_cnt     <= '0;
                        wait_cnt    <= '0;
                        ok_cnt      <= '0;
                        err_cnt     <= '0;
                        slide_count <= '0;
                        if (done_q) state <= SEARCH;
                    end
                    SEARCH: begin
                        if (good) begin
                            state   <= VERIFY;
                            ok_cnt  <= OW'(1);
                            win_cnt <= '0;
                        end else if (comma_other || win_cnt == WIN_LAST) begin
                            state    <= SLIDE;
                            rx_slide <= 1'b1;
                        end else begin
                            win_cnt <= win_cnt + 1'b1;
                        end
                    end
                    SLIDE: begin
                        if (slide_count == SLIDE_LAST) begin
                            align_fail  <= 1'b1;
                            slide_count <= '0;
                            state       <= IDLE;
                        end else begin
                            slide_count <= slide_count + 1'b1;
                            wait_cnt    <= '0;
                            state       <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (wait_cnt == WAIT_LAST) begin
                            state   <= SEARCH;
                            win_cnt <= '0;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                    VERIFY: begin
                        if (bad) begin
                            state    <= SLIDE;
                            rx_slide <= 1'b1;
                        end else if (comma0) begin
                            win_cnt <= '0;
                            ok_cnt  <= ok_cnt + 1'b1;
                            if (ok_cnt == OK_LAST) begin
                                state   <= LOCKED;
                                aligned <= 1'b1;
                                err_cnt <= '0;
                            end
                        end else if (win_cnt == WIN_LAST) begin
                            state   <= SEARCH;
                            win_cnt <= '0;
                        end else begin
                            win_cnt <= win_cnt + 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (bad) begin
                            if (err_cnt == ERR_LAST) begin
                                state       <= SEARCH;
                                aligned     <= 1'b0;
                                slide_count <= '0;
                                err_cnt     <= '0;
                                ok_cnt      <= '0;
                                win_cnt     <= '0;
                            end else begin
                                err_cnt <= err_cnt + 1'b1;
                            end
                        end else if (comma0) begin
                            err_cnt <= '0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
